// File: rtl/route_proc_if.sv
// Command / station-ID handshake bundle between the UART + barcode front end
// and the route processor.
interface route_proc_if #(
    parameter int ID_W = 6
);
    logic            cmd_rdy;
    logic [ID_W+1:0] cmd;
    logic            clr_cmd_rdy;
    logic            ID_vld;
    logic [ID_W+1:0] ID;
    logic            clr_ID_vld;

    modport master (
        output cmd_rdy, cmd, ID_vld, ID,
        input  clr_cmd_rdy, clr_ID_vld
    );

    modport slave (
        input  cmd_rdy, cmd, ID_vld, ID,
        output clr_cmd_rdy, clr_ID_vld
    );
endinterface

// File: rtl/route_proc.sv
// Route processor: destination queue driven by STOP/GO/ADD commands, pops on
// matching station IDs, gates motion and drives a piezo when the path is blocked.
module route_proc #(
    parameter int ID_W     = 6,
    parameter int DEPTH    = 4,
    parameter int BUZZ_DIV = 125000
) (
    input  logic                         clk,
    input  logic                         rst,
    route_proc_if.slave                  bus,
    input  logic                         Ok2Move,
    output logic                         go,
    output logic                         in_transit,
    output logic                         buzz,
    output logic                         buzz_n,
    output logic [ID_W-1:0]              dest_ID,
    output logic [$clog2(DEPTH+1)-1:0]   q_count,
    output logic                         arrived,
    output logic                         cmd_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int BW = $clog2(BUZZ_DIV);

    typedef enum logic [1:0] {
        OP_STOP = 2'b00,
        OP_GO   = 2'b01,
        OP_ADD  = 2'b10,
        OP_RSV  = 2'b11
    } op_e;

    typedef enum logic {
        IDLE,
        TRANSIT
    } state_e;

    state_e          state;
    logic [ID_W-1:0] slots [DEPTH];
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [BW-1:0]   buzz_cnt;

    op_e             op;
    logic [ID_W-1:0] stn;
    logic            full;
    logic            id_hit;
    logic            do_push;
    logic            bad_cmd;
    logic            buzz_en;

    assign bus.clr_cmd_rdy = bus.cmd_rdy;
    assign bus.clr_ID_vld  = bus.ID_vld;

    assign op   = op_e'(bus.cmd[ID_W+1:ID_W]);
    assign stn  = bus.cmd[ID_W-1:0];
    assign full = (q_count == CW'(DEPTH));

    assign dest_ID = (state == TRANSIT) ? slots[head] : '0;

    assign id_hit = bus.ID_vld && (bus.ID[ID_W+1:ID_W] == 2'b00) &&
                    (state == TRANSIT) && (bus.ID[ID_W-1:0] == dest_ID);

    // An arrival frees the head slot this cycle, so ADD is accepted even when full.
    assign do_push = bus.cmd_rdy && (op == OP_ADD) && (!full || id_hit);
    assign bad_cmd = bus.cmd_rdy && ((op == OP_RSV) || ((op == OP_ADD) && full && !id_hit));

    assign go      = in_transit & Ok2Move;
    assign buzz_en = in_transit & ~Ok2Move;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            head       <= '0;
            tail       <= '0;
            q_count    <= '0;
            in_transit <= 1'b0;
            arrived    <= 1'b0;
            cmd_err    <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                slots[i] <= '0;
            end
        end else begin
            arrived <= 1'b0;
            cmd_err <= 1'b0;
            if (bus.cmd_rdy && (op == OP_STOP)) begin
                state      <= IDLE;
                head       <= '0;
                tail       <= '0;
                q_count    <= '0;
                in_transit <= 1'b0;
            end else if (bus.cmd_rdy && (op == OP_GO)) begin
                slots[0]   <= stn;
                head       <= '0;
                tail       <= PW'(1);
                q_count    <= CW'(1);
                state      <= TRANSIT;
                in_transit <= 1'b1;
            end else begin
                cmd_err <= bad_cmd;
                if (id_hit) begin
                    head    <= head + 1'b1;
                    arrived <= 1'b1;
                end
                if (do_push) begin
                    slots[tail] <= stn;
                    tail        <= tail + 1'b1;
                end
                if (do_push && !id_hit) begin
                    q_count    <= q_count + 1'b1;
                    state      <= TRANSIT;
                    in_transit <= 1'b1;
                end else if (id_hit && !do_push) begin
                    q_count <= q_count - 1'b1;
                    if (q_count == CW'(1)) begin
                        state      <= IDLE;
                        in_transit <= 1'b0;
                    end
                end
            end
        end
    end

    // buzz_n is loaded with the complement of the post-edge buzz value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buzz_cnt <= '0;
            buzz     <= 1'b0;
            buzz_n   <= 1'b0;
        end else if (!buzz_en) begin
            buzz_cnt <= '0;
            buzz     <= 1'b0;
            buzz_n   <= 1'b0;
        end else if (buzz_cnt == BW'(BUZZ_DIV - 1)) begin
            buzz_cnt <= '0;
            buzz     <= ~buzz;
            buzz_n   <= buzz;
        end else begin
            buzz_cnt <= buzz_cnt + 1'b1;
            buzz_n   <= ~buzz;
        end
    end

endmodule

// File: tb/tb_route_proc.sv
// Scoreboard bench for route_proc: a queue-based reference model predicts each
// cycle's outputs; a monitor compares them after every rising edge.
module tb_route_proc;

    localparam int ID_W     = 6;
    localparam int DEPTH    = 4;
    localparam int BUZZ_DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       Ok2Move = 1'b0;
    logic       go, in_transit, buzz, buzz_n, arrived, cmd_err;
    logic [5:0] dest_ID;
    logic [2:0] q_count;

    route_proc_if #(.ID_W(ID_W)) bus ();

    route_proc #(.ID_W(ID_W), .DEPTH(DEPTH), .BUZZ_DIV(BUZZ_DIV)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .Ok2Move    (Ok2Move),
        .go         (go),
        .in_transit (in_transit),
        .buzz       (buzz),
        .buzz_n     (buzz_n),
        .dest_ID    (dest_ID),
        .q_count    (q_count),
        .arrived    (arrived),
        .cmd_err    (cmd_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int it, dest, qc, arr, err, go, bz, bzn;
    } exp_t;

    int   n_chk  = 0;
    int   n_pass = 0;
    int   mq[$];
    int   run    = 0;
    exp_t sb[$];
    bit   ok_lvl = 1'b1;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic step(input bit cv, input logic [7:0] c, input bit iv,
                        input logic [7:0] id, input bit ok);
        int   op, stn;
        bit   en, hit, arr, err;
        exp_t e;
        @(negedge clk);
        bus.cmd_rdy = cv;
        bus.cmd     = c;
        bus.ID_vld  = iv;
        bus.ID      = id;
        Ok2Move     = ok;
        #1;
        chk("clr_cmd_rdy", int'(bus.clr_cmd_rdy), int'(cv));
        chk("clr_ID_vld", int'(bus.clr_ID_vld), int'(iv));
        op  = int'(c[7:6]);
        stn = int'(c[5:0]);
        en  = (mq.size() != 0) && !ok;
        hit = iv && (id[7:6] == 2'b00) && (mq.size() != 0) && (int'(id[5:0]) == mq[0]);
        arr = 1'b0;
        err = 1'b0;
        if (cv && op == 0) begin
            mq.delete();
        end else if (cv && op == 1) begin
            mq.delete();
            mq.push_back(stn);
        end else begin
            if (hit) begin
                void'(mq.pop_front());
                arr = 1'b1;
            end
            if (cv && op == 2) begin
                if (mq.size() < DEPTH) mq.push_back(stn);
                else err = 1'b1;
            end
            if (cv && op == 3) err = 1'b1;
        end
        run   = en ? run + 1 : 0;
        e.it   = (mq.size() != 0);
        e.dest = e.it ? mq[0] : 0;
        e.qc   = mq.size();
        e.arr  = arr;
        e.err  = err;
        e.go   = e.it && ok;
        e.bz   = (run / BUZZ_DIV) % 2;
        e.bzn  = (run != 0) ? 1 - e.bz : 0;
        sb.push_back(e);
    endtask

    task automatic idle(input int n, input bit ok);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 8'h00, ok);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_transit"}, int'(in_transit), 0);
        chk({tag, "_go"}, int'(go), 0);
        chk({tag, "_buzz"}, int'(buzz), 0);
        chk({tag, "_buzz_n"}, int'(buzz_n), 0);
        chk({tag, "_dest_ID"}, int'(dest_ID), 0);
        chk({tag, "_q_count"}, int'(q_count), 0);
        chk({tag, "_arrived"}, int'(arrived), 0);
        chk({tag, "_cmd_err"}, int'(cmd_err), 0);
    endtask

    // Reset asserted mid-cycle; outputs must clear before any clock edge.
    task automatic rst_mid();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_mid");
        @(posedge clk);
        @(negedge clk);
        bus.cmd_rdy = 1'b0;
        bus.ID_vld  = 1'b0;
        rst = 1'b0;
        mq.delete();
        run = 0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("in_transit", int'(in_transit), e.it);
                chk("dest_ID", int'(dest_ID), e.dest);
                chk("q_count", int'(q_count), e.qc);
                chk("arrived", int'(arrived), e.arr);
                chk("cmd_err", int'(cmd_err), e.err);
                chk("go", int'(go), e.go);
                chk("buzz", int'(buzz), e.bz);
                chk("buzz_n", int'(buzz_n), e.bzn);
            end
        end
    end

    initial begin : driver
        int   op_sel, stn, idv;
        logic [7:0] c, id;
        bus.cmd_rdy = 1'b0;
        bus.cmd     = '0;
        bus.ID_vld  = 1'b0;
        bus.ID      = '0;
        Ok2Move     = 1'b1;
        #1 rst = 1'b1;
        #1;
        check_reset_outputs("reset");
        bus.cmd_rdy = 1'b1;
        bus.ID_vld  = 1'b1;
        #1;
        chk("reset_clr_cmd_rdy", int'(bus.clr_cmd_rdy), 1);
        chk("reset_clr_ID_vld", int'(bus.clr_ID_vld), 1);
        bus.cmd_rdy = 1'b0;
        bus.ID_vld  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // GO 0x45 with path clear
        step(1'b1, 8'h45, 1'b0, 8'h00, 1'b1);
        idle(1, 1'b1);

        // multi-stop route with an out-of-order ID first
        step(1'b1, 8'h41, 1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h82, 1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h83, 1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1, 8'h02, 1'b1);
        step(1'b0, 8'h00, 1'b1, 8'h01, 1'b1);
        step(1'b0, 8'h00, 1'b1, 8'h02, 1'b1);
        step(1'b0, 8'h00, 1'b1, 8'h03, 1'b1);
        idle(1, 1'b1);

        // full queue: overflow rejected, ADD with arrival accepted
        step(1'b1, 8'h41, 1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h82, 1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h83, 1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h84, 1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h85, 1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h86, 1'b1, 8'h01, 1'b1);
        step(1'b1, 8'hC7, 1'b0, 8'h00, 1'b1);
        idle(1, 1'b1);

        // blocked path: buzzer runs, then clears
        step(1'b1, 8'h41, 1'b0, 8'h00, 1'b0);
        idle(12, 1'b0);
        idle(2, 1'b1);

        // STOP beats arrival; invalid-prefix ID ignored
        step(1'b1, 8'h41, 1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h82, 1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h00, 1'b1, 8'h01, 1'b1);
        step(1'b1, 8'h41, 1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1, 8'hC1, 1'b1);
        step(1'b1, 8'h43, 1'b1, 8'h01, 1'b1);
        idle(1, 1'b1);

        // reset mid-route abandons it
        step(1'b1, 8'h41, 1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h82, 1'b0, 8'h00, 1'b0);
        idle(2, 1'b0);
        rst_mid();
        step(1'b0, 8'h00, 1'b1, 8'h01, 1'b1);
        idle(2, 1'b1);

        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 7) == 0) ok_lvl = ~ok_lvl;
            op_sel = $urandom_range(0, 9);
            stn    = $urandom_range(0, 7);
            c[5:0] = 6'(stn);
            c[7:6] = (op_sel == 0) ? 2'b00 : (op_sel <= 2) ? 2'b01 :
                     (op_sel <= 8) ? 2'b10 : 2'b11;
            if (mq.size() != 0 && $urandom_range(0, 1) == 1) idv = mq[0];
            else idv = $urandom_range(0, 7);
            id[5:0] = 6'(idv);
            id[7:6] = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            step($urandom_range(0, 2) == 0, c, $urandom_range(0, 1) == 1, id, ok_lvl);
            if (i % 500 == 499) rst_mid();
        end
        idle(1, 1'b1);

        for (int k = 0; k < 20 && sb.size() != 0; k++) @(posedge clk);
        @(posedge clk);
        #3;
        chk("scoreboard_drain", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
